// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths and small address helpers.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  // A data access is word-aligned only when the two byte-offset bits are zero.
  function automatic logic is_misaligned(input logic [1:0] byte_offset);
    return byte_offset != 2'b00;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Word-addressed data RAM: combinational read, write on the rising clock edge.
// Reads see the array directly, so a word written at one edge is returned
// to any access of that word during the following cycle.
module data_mem
  import mips_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Commit a store to the addressed word; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wd;
    end
  end

  assign rd = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage data access plus the MEM/WB pipeline register.
// Stores are gated here (alignment, stall, clear); the W register captures
// control, ALU result and load data, and a sticky flag records any
// misaligned access that reached the memory unstalled.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  regwriteM,
  input  logic                  memtoRegM,
  input  logic                  memWriteM,
  input  logic [DATA_W-1:0]     aluOutM,
  input  logic [DATA_W-1:0]     writeDataM,
  input  logic [REG_ADDR_W-1:0] writeRegM,
  input  logic                  stallW,
  output logic                  regwriteW,
  output logic                  memtoRegW,
  output logic [DATA_W-1:0]     readDataW,
  output logic [DATA_W-1:0]     aluOutW,
  output logic [REG_ADDR_W-1:0] writeRegW,
  output logic [DATA_W-1:0]     resultW,
  output logic                  memFault
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     word_addr;
  logic [DATA_W-1:0] read_data;
  logic              mem_access;
  logic              misaligned;
  logic              store_en;
  logic              unused_addr_bits;

  // Upper address bits are ignored so accesses wrap modulo DEPTH*4 bytes.
  assign word_addr        = aluOutM[AW+1:2];
  assign unused_addr_bits = ^aluOutM[DATA_W-1:AW+2];

  assign mem_access = memWriteM | memtoRegM;
  assign misaligned = mem_access & is_misaligned(aluOutM[1:0]);
  assign store_en   = memWriteM & ~misaligned & ~stallW & ~clr;

  data_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk  (clk),
    .we   (store_en),
    .addr (word_addr),
    .wd   (writeDataM),
    .rd   (read_data)
  );

  // W register: clear wins over stall; a stall holds everything; otherwise
  // capture M, dropping the register write of a faulting access.
  always_ff @(posedge clk) begin
    if (clr) begin
      regwriteW <= 1'b0;
      memtoRegW <= 1'b0;
      readDataW <= '0;
      aluOutW   <= '0;
      writeRegW <= '0;
      memFault  <= 1'b0;
    end else if (!stallW) begin
      regwriteW <= regwriteM & ~misaligned;
      memtoRegW <= memtoRegM;
      readDataW <= read_data;
      aluOutW   <= aluOutM;
      writeRegW <= writeRegM;
      memFault  <= memFault | misaligned;
    end
  end

  assign resultW = memtoRegW ? readDataW : aluOutW;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage with DEPTH=64.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        clr;
  logic        regwriteM, memtoRegM, memWriteM;
  logic [31:0] aluOutM, writeDataM;
  logic [4:0]  writeRegM;
  logic        stallW;
  logic        regwriteW, memtoRegW;
  logic [31:0] readDataW, aluOutW, resultW;
  logic [4:0]  writeRegW;
  logic        memFault;

  int checks = 0;
  int failures = 0;

  mem_wb_stage #(.DEPTH(64)) dut (
    .clk        (clk),
    .clr        (clr),
    .regwriteM  (regwriteM),
    .memtoRegM  (memtoRegM),
    .memWriteM  (memWriteM),
    .aluOutM    (aluOutM),
    .writeDataM (writeDataM),
    .writeRegM  (writeRegM),
    .stallW     (stallW),
    .regwriteW  (regwriteW),
    .memtoRegW  (memtoRegW),
    .readDataW  (readDataW),
    .aluOutW    (aluOutW),
    .writeRegW  (writeRegW),
    .resultW    (resultW),
    .memFault   (memFault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one M-stage instruction, then advance past the next rising edge.
  task automatic applyStimulus(input logic c, input logic st, input logic mw,
                               input logic mtr, input logic rw,
                               input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] wr);
    clr        = c;
    stallW     = st;
    memWriteM  = mw;
    memtoRegM  = mtr;
    regwriteM  = rw;
    aluOutM    = alu;
    writeDataM = wd;
    writeRegM  = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(0, 0, 1, 0, 0, addr, data, 5'd0);
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] wr);
    applyStimulus(0, 0, 0, 1, 1, addr, 32'h0, wr);
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    checkOutput("rst_regwrite", {31'b0, regwriteW}, 32'h0);
    checkOutput("rst_memtoreg", {31'b0, memtoRegW}, 32'h0);
    checkOutput("rst_readdata", readDataW, 32'h0);
    checkOutput("rst_aluout", aluOutW, 32'h0);
    checkOutput("rst_writereg", {27'b0, writeRegW}, 32'h0);
    checkOutput("rst_fault", {31'b0, memFault}, 32'h0);

    // Store then load the next cycle.
    store(32'h10, 32'hDEADBEEF);
    checkOutput("st_regwrite", {31'b0, regwriteW}, 32'h0);
    load(32'h10, 5'd4);
    checkOutput("ld_readdata", readDataW, 32'hDEADBEEF);
    checkOutput("ld_memtoreg", {31'b0, memtoRegW}, 32'h1);
    checkOutput("ld_result", resultW, 32'hDEADBEEF);
    checkOutput("ld_regwrite", {31'b0, regwriteW}, 32'h1);
    checkOutput("ld_writereg", {27'b0, writeRegW}, 32'd4);

    // ALU pass-through.
    applyStimulus(0, 0, 0, 0, 1, 32'h123, 32'h0, 5'd9);
    checkOutput("alu_regwrite", {31'b0, regwriteW}, 32'h1);
    checkOutput("alu_writereg", {27'b0, writeRegW}, 32'd9);
    checkOutput("alu_result", resultW, 32'h123);
    checkOutput("alu_memtoreg", {31'b0, memtoRegW}, 32'h0);
    checkOutput("alu_nofault", {31'b0, memFault}, 32'h0);

    // Misaligned store is suppressed and raises the sticky fault.
    store(32'h20, 32'h11112222);
    store(32'h22, 32'h99999999);
    checkOutput("mis_fault", {31'b0, memFault}, 32'h1);
    load(32'h20, 5'd2);
    checkOutput("mis_word8", readDataW, 32'h11112222);
    checkOutput("mis_sticky1", {31'b0, memFault}, 32'h1);
    load(32'h13, 5'd6);
    checkOutput("mis_ld_regwrite", {31'b0, regwriteW}, 32'h0);
    checkOutput("mis_ld_writereg", {27'b0, writeRegW}, 32'd6);
    applyStimulus(0, 0, 0, 0, 1, 32'h7, 32'h0, 5'd1);
    checkOutput("nonaccess_regwrite", {31'b0, regwriteW}, 32'h1);
    checkOutput("mis_sticky2", {31'b0, memFault}, 32'h1);
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    checkOutput("fault_cleared", {31'b0, memFault}, 32'h0);

    // Stall: W frozen, stalled store does not reach RAM.
    store(32'h04, 32'h0000AAAA);
    applyStimulus(0, 0, 0, 0, 1, 32'h55, 32'h0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0, 0, 32'h04, 32'hCCCCCCCC, 5'd7);
      checkOutput("stall_result", resultW, 32'h55);
      checkOutput("stall_writereg", {27'b0, writeRegW}, 32'd3);
      checkOutput("stall_regwrite", {31'b0, regwriteW}, 32'h1);
    end
    load(32'h04, 5'd5);
    checkOutput("stall_word1_kept", readDataW, 32'h0000AAAA);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0, 0, 32'h04, 32'hBBBBBBBB, 5'd0);
    end
    checkOutput("stall_hold_ld", readDataW, 32'h0000AAAA);
    store(32'h04, 32'hBBBBBBBB);
    load(32'h04, 5'd5);
    checkOutput("stall_commit", readDataW, 32'hBBBBBBBB);
    applyStimulus(0, 1, 1, 0, 0, 32'h06, 32'h0, 5'd0);
    checkOutput("stall_no_fault", {31'b0, memFault}, 32'h0);

    // Reset mid-operation with stall and store presented.
    load(32'h21, 5'd8);
    checkOutput("pre_clr_fault", {31'b0, memFault}, 32'h1);
    applyStimulus(0, 0, 0, 0, 1, 32'h77, 32'h0, 5'd12);
    applyStimulus(1, 1, 1, 0, 1, 32'h04, 32'hEEEEEEEE, 5'd13);
    checkOutput("clr_regwrite", {31'b0, regwriteW}, 32'h0);
    checkOutput("clr_aluout", aluOutW, 32'h0);
    checkOutput("clr_writereg", {27'b0, writeRegW}, 32'h0);
    checkOutput("clr_result", resultW, 32'h0);
    checkOutput("clr_fault", {31'b0, memFault}, 32'h0);
    load(32'h04, 5'd1);
    checkOutput("clr_ram_word1", readDataW, 32'hBBBBBBBB);
    load(32'h10, 5'd1);
    checkOutput("clr_ram_word4", readDataW, 32'hDEADBEEF);

    // Address wrap-around modulo 256 bytes.
    store(32'h100, 32'hA5A5A5A5);
    load(32'h000, 5'd10);
    checkOutput("wrap_load", resultW, 32'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
